neuron_mac: RTL and testbench

Streaming signed fixed-point multiply-accumulate neuron, directly upstream of the tanh piecewise-linear activation. It accepts one (x, w) pair of Q8.8 operands per handshake and accumulates a configurable number of products at full precision. It then adds a Q8.8 bias, rounds, and saturates back to 16-bit Q8.8. The result is presented as the activation input behind a valid/ready output handshake.

---
 rtl/neuron_mac.sv | 156 +++++++++++++++
 tb/tb_neuron_mac.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac.sv
// Streaming signed Q8.8 multiply-accumulate neuron: accumulates len products at full
// precision, adds a bias, rounds half-up and saturates to Q8.8 for the activation stage.
module neuron_mac #(
    parameter int DATA_W = 16,
    parameter int FRAC   = 8,
    parameter int ACC_W  = 40,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [DATA_W-1:0] bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x_in,
    input  logic [DATA_W-1:0] w_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] y_out,
    output logic              sat
);

    typedef enum logic [1:0] {
        ST_ACC = 2'd0,
        ST_FIN = 2'd1,
        ST_OUT = 2'd2
    } state_t;

    localparam int PROD_W = 2 * DATA_W;
    localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) << (FRAC - 1);

    state_t                    state_r;
    state_t                    state_s;
    logic [LEN_W-1:0]          cnt_r;
    logic [LEN_W-1:0]          len_q_r;
    logic [DATA_W-1:0]         bias_q_r;
    logic signed [ACC_W-1:0]   acc_r;

    logic                      fire_s;
    logic [LEN_W-1:0]          len_eff_s;
    logic [LEN_W-1:0]          len_cur_s;
    logic                      last_s;
    logic signed [PROD_W-1:0]  prod_s;
    logic signed [ACC_W-1:0]   prod_ext_s;
    logic signed [ACC_W-1:0]   bias_sh_s;
    logic signed [ACC_W-1:0]   pre_s;
    logic signed [ACC_W-1:0]   rnd_s;
    logic [DATA_W:0]           clip_s;

    // Clip a rounded full-precision value to DATA_W; returns {sat, y}.
    function automatic logic [DATA_W:0] clip_fn(input logic signed [ACC_W-1:0] v);
        logic [DATA_W:0] res;
        if (v > Y_MAX) begin
            res = {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
        end else if (v < Y_MIN) begin
            res = {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            res = {1'b0, v[DATA_W-1:0]};
        end
        return res;
    endfunction

    assign in_ready   = (state_r == ST_ACC);
    assign fire_s     = in_valid && (state_r == ST_ACC);
    assign len_eff_s  = (cfg_len == {LEN_W{1'b0}}) ? LEN_W'(1) : cfg_len;
    // The first beat compares against the live cfg_len because len_q is latched on that same edge.
    assign len_cur_s  = (cnt_r == {LEN_W{1'b0}}) ? len_eff_s : len_q_r;
    assign last_s     = (({1'b0, cnt_r} + (LEN_W+1)'(1)) == {1'b0, len_cur_s});
    assign prod_s     = $signed(x_in) * $signed(w_in);
    assign prod_ext_s = {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
    assign bias_sh_s  = {{(ACC_W-DATA_W){bias_q_r[DATA_W-1]}}, bias_q_r} <<< FRAC;
    assign pre_s      = acc_r + bias_sh_s + RND_HALF;
    assign rnd_s      = pre_s >>> FRAC;
    assign clip_s     = clip_fn(rnd_s);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_ACC;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_ACC: begin
                if (fire_s && last_s) begin
                    state_s = ST_FIN;
                end else begin
                    state_s = ST_ACC;
                end
            end
            ST_FIN: begin
                state_s = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_s = ST_ACC;
                end else begin
                    state_s = ST_OUT;
                end
            end
            default: begin
                state_s = ST_ACC;
            end
        endcase
    end

    // Accumulator, per-vector configuration and registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= {LEN_W{1'b0}};
            len_q_r   <= LEN_W'(1);
            bias_q_r  <= {DATA_W{1'b0}};
            acc_r     <= {ACC_W{1'b0}};
            y_out     <= {DATA_W{1'b0}};
            sat       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state_r)
                ST_ACC: begin
                    if (fire_s) begin
                        if (cnt_r == {LEN_W{1'b0}}) begin
                            len_q_r  <= len_eff_s;
                            bias_q_r <= bias;
                            acc_r    <= prod_ext_s;
                        end else begin
                            acc_r    <= acc_r + prod_ext_s;
                        end
                        cnt_r <= last_s ? {LEN_W{1'b0}} : (cnt_r + LEN_W'(1));
                    end
                end
                ST_FIN: begin
                    sat       <= clip_s[DATA_W];
                    y_out     <= clip_s[DATA_W-1:0];
                    out_valid <= 1'b1;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc_r     <= {ACC_W{1'b0}};
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: the driver queues hand-computed results, and a monitor
// compares them against each output handshake.
module tb_neuron_mac;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cfg_len;
    logic [15:0] bias;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x_in;
    logic [15:0] w_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] y_out;
    logic        sat;

    logic [16:0] exp_q[$];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    neuron_mac dut (
        .clk(clk), .rst(rst), .cfg_len(cfg_len), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .w_in(w_in),
        .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out), .sat(sat)
    );

    // Monitor: compare each presented result at the handshake against the queue head.
    always @(negedge clk) begin
        logic [16:0] e;
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_out got sat=%0b y=%h", sat, y_out);
            end else begin
                e = exp_q.pop_front();
                if ({sat, y_out} !== e) begin
                    failures++;
                    $display("FAIL result got sat=%0b y=%h want sat=%0b y=%h",
                             sat, y_out, e[16], e[15:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic start_vec(input logic [7:0] len, input logic [15:0] b,
                             input logic [15:0] y_e, input logic s_e);
        cfg_len = len;
        bias    = b;
        exp_q.push_back({s_e, y_e});
    endtask

    task automatic beat(input logic [15:0] x, input logic [15:0] w);
        int t;
        @(negedge clk);
        in_valid = 1'b1;
        x_in     = x;
        w_in     = w;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout got=in_ready_low want=in_ready_high");
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout got=%0d pending want=0", exp_q.size());
            exp_q.delete();
        end
        #1;
    endtask

    initial begin
        logic [15:0] held_y;
        logic        held_s;
        int          t;
        rst = 1'b1; cfg_len = 8'd1; bias = 16'h0000; in_valid = 1'b0;
        x_in = 16'h0000; w_in = 16'h0000; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_y", {16'd0, y_out}, 32'd0);
        check("reset_sat", {31'd0, sat}, 32'd0);

        // Basic product with latency check.
        start_vec(8'd1, 16'h0000, 16'h0100, 1'b0);
        beat(16'h0100, 16'h0100);
        check("fin_out_valid", {31'd0, out_valid}, 32'd0);
        check("fin_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        check("lat_out_valid", {31'd0, out_valid}, 32'd1);
        check("lat_y", {16'd0, y_out}, 32'h0100);
        drain();

        // Multi-term with bias; later cfg_len/bias changes must be ignored.
        start_vec(8'd4, 16'h0040, 16'h0440, 1'b0);
        beat(16'h0080, 16'h0200);
        cfg_len = 8'd2; bias = 16'h7FFF;
        for (int i = 0; i < 3; i++) beat(16'h0080, 16'h0200);
        drain();
        // Same vector with an idle cycle between beats.
        start_vec(8'd4, 16'h0040, 16'h0440, 1'b0);
        for (int i = 0; i < 4; i++) begin
            beat(16'h0080, 16'h0200);
            @(posedge clk); #1;
        end
        drain();

        // Saturation and len=0.
        start_vec(8'd2, 16'h0000, 16'h7FFF, 1'b1);
        beat(16'h7FFF, 16'h7FFF); beat(16'h7FFF, 16'h7FFF);
        drain();
        start_vec(8'd1, 16'h0000, 16'h8000, 1'b1);
        beat(16'h8000, 16'h7FFF);
        drain();
        start_vec(8'd0, 16'h0000, 16'h0200, 1'b0);
        beat(16'h0100, 16'h0200);
        drain();

        // Rounding.
        start_vec(8'd1, 16'h0000, 16'h0001, 1'b0);
        beat(16'h0001, 16'h0080);
        drain();
        start_vec(8'd1, 16'h0000, 16'h0000, 1'b0);
        beat(16'h0001, 16'h007F);
        drain();
        start_vec(8'd1, 16'h0000, 16'h0000, 1'b0);
        beat(16'hFFFF, 16'h0080);
        drain();

        // Backpressure: result held, no beats consumed while stalled.
        out_ready = 1'b0;
        start_vec(8'd1, 16'h0000, 16'h0300, 1'b0);
        beat(16'h0300, 16'h0100);
        t = 0;
        while (!out_valid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        check("bp_out_valid_rise", {31'd0, out_valid}, 32'd1);
        held_y = y_out;
        held_s = sat;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; x_in = 16'h1234; w_in = 16'h4321;
            @(posedge clk); #1;
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_y_stable", {16'd0, y_out}, {16'd0, held_y});
            check("bp_sat_stable", {31'd0, sat}, {31'd0, held_s});
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("hs_in_ready", {31'd0, in_ready}, 32'd1);
        check("hs_out_valid", {31'd0, out_valid}, 32'd0);
        drain();

        // Reset mid-vector discards the partial sum.
        cfg_len = 8'd4; bias = 16'h0000;
        beat(16'h0100, 16'h0100); beat(16'h0100, 16'h0100);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_y", {16'd0, y_out}, 32'd0);
        start_vec(8'd1, 16'h0000, 16'h0100, 1'b0);
        beat(16'h0100, 16'h0100);
        drain();

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
